scr1_dmem_copy_engine: RTL and testbench

//  Initiator (master) on the core-style dmem interface (req/req_ack/cmd/width/addr/wdata -> rdata/resp).

---
 rtl/scr1_dmem_copy_engine_pkg.sv | 22 ++
 rtl/scr1_dmem_copy_engine_if.sv | 14 +
 rtl/scr1_dmem_copy_timeout.sv | 19 +
 rtl/scr1_dmem_copy_engine.sv | 100 ++++++++++
 tb/tb_scr1_dmem_copy_engine.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/scr1_dmem_copy_engine_pkg.sv
// scr1_dmem_copy_engine_pkg: dmem bus enums, widths and address helper shared by the copy engine slice
package scr1_dmem_copy_engine_pkg;
    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;
    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;
    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
    function automatic logic [SCR1_DMEM_AWIDTH-1:0] word_align(input logic [SCR1_DMEM_AWIDTH-1:0] a);
        return {a[SCR1_DMEM_AWIDTH-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/scr1_dmem_copy_engine_if.sv
// scr1_dmem_copy_engine_if: core-style dmem request/response bus
interface scr1_dmem_copy_engine_if;
    import scr1_dmem_copy_engine_pkg::*;
    logic                        req;
    logic                        req_ack;
    type_scr1_mem_cmd_e          cmd;
    type_scr1_mem_width_e        width;
    logic [SCR1_DMEM_AWIDTH-1:0] addr;
    logic [SCR1_DMEM_DWIDTH-1:0] wdata;
    logic [SCR1_DMEM_DWIDTH-1:0] rdata;
    type_scr1_mem_resp_e         resp;
    modport master (output req, cmd, width, addr, wdata, input req_ack, rdata, resp);
    modport slave  (input req, cmd, width, addr, wdata, output req_ack, rdata, resp);
endinterface

// File: rtl/scr1_dmem_copy_timeout.sv
// scr1_dmem_copy_timeout: loadable down-counter flagging a handshake wait that ran TIMEOUT cycles
module scr1_dmem_copy_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst || load) cnt_q <= CW'(TIMEOUT);
        else if (en && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
    // fires on the TIMEOUT-th consecutive stalled cycle so the FSM leaves at that edge
    assign expired = (TIMEOUT != 0) && en && (cnt_q == CW'(1));
endmodule

// File: rtl/scr1_dmem_copy_engine.sv
// scr1_dmem_copy_engine: dmem initiator that copies or fills word blocks one transaction at a time
module scr1_dmem_copy_engine
    import scr1_dmem_copy_engine_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic                        cfg_mode,
    input  logic [SCR1_DMEM_AWIDTH-1:0] cfg_src_addr,
    input  logic [SCR1_DMEM_AWIDTH-1:0] cfg_dst_addr,
    input  logic [LEN_W-1:0]            cfg_len,
    input  logic [SCR1_DMEM_DWIDTH-1:0] cfg_fill_data,
    output logic                        stat_busy,
    output logic                        stat_done,
    output logic                        stat_err,
    output logic [SCR1_DMEM_AWIDTH-1:0] stat_err_addr,
    output logic [LEN_W-1:0]            stat_count,
    scr1_dmem_copy_engine_if.master     dmem
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_e;
    state_e                      state_q, state_d;
    logic                        mode_q;
    logic [SCR1_DMEM_AWIDTH-1:0] src_q, dst_q;
    logic [LEN_W-1:0]            rem_q;
    logic [SCR1_DMEM_DWIDTH-1:0] wdata_q;
    logic                        is_req, is_wait, is_wr, resp_ok, fail, tmo_en, tmo_exp;
    assign is_req  = state_q == RD_REQ || state_q == WR_REQ;
    assign is_wait = state_q == RD_WAIT || state_q == WR_WAIT;
    assign is_wr   = state_q == WR_REQ || state_q == WR_WAIT;
    assign resp_ok = is_wait && dmem.resp == SCR1_MEM_RESP_RDY_OK;
    assign tmo_en  = is_req ? !dmem.req_ack : is_wait && dmem.resp == SCR1_MEM_RESP_NOTRDY;
    assign fail    = (is_wait && dmem.resp == SCR1_MEM_RESP_RDY_ER) || tmo_exp;
    scr1_dmem_copy_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (state_d != state_q),
        .en      (tmo_en),
        .expired (tmo_exp)
    );
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !cfg_start ? IDLE : cfg_len == '0 ? DONE : cfg_mode ? WR_REQ : RD_REQ;
            RD_REQ:  state_d = fail ? DONE : dmem.req_ack ? RD_WAIT : RD_REQ;
            RD_WAIT: state_d = fail ? DONE : resp_ok ? WR_REQ : RD_WAIT;
            WR_REQ:  state_d = fail ? DONE : dmem.req_ack ? WR_WAIT : WR_REQ;
            WR_WAIT: state_d = fail ? DONE : !resp_ok ? WR_WAIT : rem_q == LEN_W'(1) ? DONE : mode_q ? WR_REQ : RD_REQ;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        dmem.req   = is_req;
        dmem.cmd   = is_wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        dmem.width = SCR1_MEM_WIDTH_WORD;
        dmem.addr  = is_wr ? dst_q : src_q;
        dmem.wdata = wdata_q;
        stat_busy  = state_q != IDLE && state_q != DONE;
        stat_done  = state_q == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= 1'b0;
            src_q         <= '0;
            dst_q         <= '0;
            rem_q         <= '0;
            wdata_q       <= '0;
            stat_err      <= 1'b0;
            stat_err_addr <= '0;
            stat_count    <= '0;
        end else begin
            if (state_q == IDLE && cfg_start) begin
                mode_q     <= cfg_mode;
                src_q      <= word_align(cfg_src_addr);
                dst_q      <= word_align(cfg_dst_addr);
                rem_q      <= cfg_len;
                wdata_q    <= cfg_fill_data;
                stat_err   <= 1'b0;
                stat_count <= '0;
            end
            if (resp_ok && state_q == RD_WAIT) wdata_q <= dmem.rdata;
            if (resp_ok && state_q == WR_WAIT) begin
                stat_count <= stat_count + LEN_W'(1);
                src_q      <= src_q + SCR1_DMEM_AWIDTH'(4);
                dst_q      <= dst_q + SCR1_DMEM_AWIDTH'(4);
                rem_q      <= rem_q - LEN_W'(1);
            end
            if (fail) begin
                stat_err      <= 1'b1;
                stat_err_addr <= dmem.addr;
            end
        end
    end
endmodule

// File: tb/tb_scr1_dmem_copy_engine.sv
// tb_scr1_dmem_copy_engine: directed checks of the copy engine against a 1-cycle TCM responder
module tb_scr1_dmem_copy_engine;
    import scr1_dmem_copy_engine_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0, cfg_mode = 1'b0;
    logic [31:0] cfg_src_addr = '0, cfg_dst_addr = '0, cfg_fill_data = '0;
    logic [15:0] cfg_len = '0;
    logic        stat_busy, stat_done, stat_err;
    logic [31:0] stat_err_addr;
    logic [15:0] stat_count;
    always #5 clk = ~clk;
    scr1_dmem_copy_engine_if bus ();
    scr1_dmem_copy_engine #(.LEN_W(16), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_mode      (cfg_mode),
        .cfg_src_addr  (cfg_src_addr),
        .cfg_dst_addr  (cfg_dst_addr),
        .cfg_len       (cfg_len),
        .cfg_fill_data (cfg_fill_data),
        .stat_busy     (stat_busy),
        .stat_done     (stat_done),
        .stat_err      (stat_err),
        .stat_err_addr (stat_err_addr),
        .stat_count    (stat_count),
        .dmem          (bus.master)
    );
    // TCM responder: ack follows ack_en, response arrives the cycle after the handshake
    logic                ack_en = 1'b1, stuck = 1'b0;
    int                  err_at_rd = -1;
    logic [31:0]         mem [256];
    logic                written [256];
    logic [31:0]         wr_log [64];
    int                  rd_cnt = 0, wr_cnt = 0, req_cyc = 0, bad_width = 0;
    type_scr1_mem_resp_e resp_r = SCR1_MEM_RESP_NOTRDY;
    logic [31:0]         rdata_r = '0;
    assign bus.req_ack = ack_en;
    assign bus.resp    = resp_r;
    assign bus.rdata   = rdata_r;
    function automatic logic [31:0] word_at(input logic [7:0] i);
        return written[i] ? mem[i] : 32'hC0DE0000 + {24'h0, i};
    endfunction
    always @(posedge clk) begin
        resp_r <= SCR1_MEM_RESP_NOTRDY;
        if (rst) begin
            for (int i = 0; i < 256; i++) written[i] <= 1'b0;
        end else begin
            if (bus.req) begin
                req_cyc <= req_cyc + 1;
                if (bus.width != SCR1_MEM_WIDTH_WORD) bad_width <= bad_width + 1;
            end
            if (bus.req && ack_en) begin
                if (bus.cmd == SCR1_MEM_CMD_WR) begin
                    mem[bus.addr[9:2]]     <= bus.wdata;
                    written[bus.addr[9:2]] <= 1'b1;
                    wr_log[wr_cnt[5:0]]    <= bus.addr;
                    wr_cnt                 <= wr_cnt + 1;
                    resp_r <= stuck ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
                end else begin
                    rdata_r <= word_at(bus.addr[9:2]);
                    resp_r  <= (rd_cnt == err_at_rd) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                    rd_cnt  <= rd_cnt + 1;
                end
            end
        end
    end
    int total = 0, bad = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic start_job(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] len, input logic [31:0] fill);
        cfg_mode = mode; cfg_src_addr = src; cfg_dst_addr = dst; cfg_len = len; cfg_fill_data = fill;
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
    endtask
    task automatic wait_idle(input string tag);
        int n = 0;
        while ((stat_busy || stat_done) && n < 200) begin step(1); n++; end
        chk(tag, {31'b0, stat_busy}, 32'd0);
    endtask
    initial begin
        int w0, r0, q0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int w0, r0, q0;
        step(2);
        chk("rst_req", {31'b0, bus.req}, 0);
        chk("rst_cmd", {31'b0, bus.cmd}, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_busy", {31'b0, stat_busy}, 0);
        chk("rst_done", {31'b0, stat_done}, 0);
        chk("rst_err", {31'b0, stat_err}, 0);
        chk("rst_count", {16'b0, stat_count}, 0);
        rst = 1'b0;
        step(1);
        // 1: copy 4 words 0x100 -> 0x200; 1 start + 16 + 1 DONE cycles
        w0 = wr_cnt;
        start_job(1'b0, 32'h100, 32'h200, 16'd4, 32'h0);
        step(15);
        chk("t1_done_early", {31'b0, stat_done}, 0);
        chk("t1_busy", {31'b0, stat_busy}, 1);
        step(1);
        chk("t1_done", {31'b0, stat_done}, 1);
        chk("t1_busy_at_done", {31'b0, stat_busy}, 0);
        chk("t1_count", {16'b0, stat_count}, 4);
        step(1);
        chk("t1_done_pulse", {31'b0, stat_done}, 0);
        chk("t1_writes", wr_cnt - w0, 4);
        for (int i = 0; i < 4; i++) chk("t1_data", word_at(8'(128 + i)), 32'hC0DE0040 + 32'(i));
        // 2: fill 3 words at 0x40
        w0 = wr_cnt; r0 = rd_cnt;
        start_job(1'b1, 32'h0, 32'h40, 16'd3, 32'hDEADBEEF);
        step(6);
        chk("t2_done", {31'b0, stat_done}, 1);
        chk("t2_count", {16'b0, stat_count}, 3);
        chk("t2_no_reads", rd_cnt - r0, 0);
        chk("t2_writes", wr_cnt - w0, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_wr_addr", wr_log[(w0 + i) & 63], 32'h40 + 32'(4 * i));
            chk("t2_data", word_at(8'(16 + i)), 32'hDEADBEEF);
        end
        wait_idle("t2_idle");
        // 3: zero length
        q0 = req_cyc;
        start_job(1'b0, 32'h100, 32'h200, 16'd0, 32'h0);
        chk("t3_done", {31'b0, stat_done}, 1);
        chk("t3_busy", {31'b0, stat_busy}, 0);
        step(1);
        chk("t3_done_pulse", {31'b0, stat_done}, 0);
        step(2);
        chk("t3_no_req", req_cyc - q0, 0);
        chk("t3_err", {31'b0, stat_err}, 0);
        chk("t3_count", {16'b0, stat_count}, 0);
        // 4: error response on the 2nd read
        r0 = rd_cnt; q0 = req_cyc;
        err_at_rd = r0 + 1;
        start_job(1'b0, 32'h100, 32'h240, 16'd3, 32'h0);
        step(6);
        chk("t4_done", {31'b0, stat_done}, 1);
        chk("t4_err", {31'b0, stat_err}, 1);
        chk("t4_err_addr", stat_err_addr, 32'h104);
        chk("t4_count", {16'b0, stat_count}, 1);
        step(4);
        chk("t4_reqs", req_cyc - q0, 3);
        chk("t4_err_sticky", {31'b0, stat_err}, 1);
        err_at_rd = -1;
        // 5a: ack held low for 5 cycles, request must stay stable
        ack_en = 1'b0;
        start_job(1'b1, 32'h0, 32'h60, 16'd1, 32'h12345678);
        chk("t5_err_cleared", {31'b0, stat_err}, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t5_req_hold", {31'b0, bus.req}, 1);
            chk("t5_cmd_hold", {31'b0, bus.cmd}, 1);
            chk("t5_addr_hold", bus.addr, 32'h60);
            chk("t5_wdata_hold", bus.wdata, 32'h12345678);
            if (i < 4) step(1);
        end
        ack_en = 1'b1;
        step(2);
        chk("t5_done", {31'b0, stat_done}, 1);
        chk("t5_count", {16'b0, stat_count}, 1);
        chk("t5_data", word_at(8'd24), 32'h12345678);
        step(1);
        // 5b: write response never arrives, TIMEOUT=8
        q0 = req_cyc;
        stuck = 1'b1;
        start_job(1'b1, 32'h0, 32'h80, 16'd1, 32'hA5A5A5A5);
        step(8);
        chk("t5_tmo_early", {31'b0, stat_done}, 0);
        step(1);
        chk("t5_tmo_done", {31'b0, stat_done}, 1);
        chk("t5_tmo_err", {31'b0, stat_err}, 1);
        chk("t5_tmo_addr", stat_err_addr, 32'h80);
        chk("t5_tmo_count", {16'b0, stat_count}, 0);
        step(2);
        chk("t5_tmo_reqs", req_cyc - q0, 1);
        stuck = 1'b0;
        // 6a: start while busy is ignored
        start_job(1'b0, 32'h300, 32'h380, 16'd2, 32'h0);
        step(2);
        cfg_mode = 1'b1; cfg_len = 16'd7; cfg_dst_addr = 32'h180; cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
        step(5);
        chk("t6_done", {31'b0, stat_done}, 1);
        chk("t6_count", {16'b0, stat_count}, 2);
        chk("t6_data0", word_at(8'hE0), 32'hC0DE00C0);
        chk("t6_data1", word_at(8'hE1), 32'hC0DE00C1);
        step(1);
        // 6b: reset mid-copy
        start_job(1'b0, 32'h100, 32'h200, 16'd4, 32'h0);
        step(6);
        chk("t6_mid_busy", {31'b0, stat_busy}, 1);
        rst = 1'b1;
        step(1);
        chk("t6_rst_req", {31'b0, bus.req}, 0);
        chk("t6_rst_cmd", {31'b0, bus.cmd}, 0);
        chk("t6_rst_addr", bus.addr, 0);
        chk("t6_rst_wdata", bus.wdata, 0);
        chk("t6_rst_busy", {31'b0, stat_busy}, 0);
        chk("t6_rst_done", {31'b0, stat_done}, 0);
        chk("t6_rst_err_addr", stat_err_addr, 0);
        chk("t6_rst_count", {16'b0, stat_count}, 0);
        rst = 1'b0;
        q0 = req_cyc;
        step(3);
        chk("t6_quiet_busy", {31'b0, stat_busy}, 0);
        chk("t6_quiet_req", req_cyc - q0, 0);
        // 6c: new job after reset, unaligned destination
        w0 = wr_cnt;
        start_job(1'b1, 32'h0, 32'h3C3, 16'd2, 32'h0BADF00D);
        step(4);
        chk("t6c_done", {31'b0, stat_done}, 1);
        chk("t6c_count", {16'b0, stat_count}, 2);
        chk("t6c_addr0", wr_log[w0 & 63], 32'h3C0);
        chk("t6c_addr1", wr_log[(w0 + 1) & 63], 32'h3C4);
        chk("t6c_data", word_at(8'hF1), 32'h0BADF00D);
        chk("width_word", bad_width, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
